isp_1bit_morph: RTL
===================

# isp_1bit_morph

Parametrised 1-bit morphology stage for the ISP binary path. It takes the thresholded 1-bit pixel stream with its href/vsync/write-enable framing. It applies a KSIZE×KSIZE erosion or dilation, or passes the stream through, with the mode selected at run time and latched per frame. The stage sits between binarisation and the RGB565 display/overlay writer, and supersedes the fixed 3×3 erosion stage.

## Interface
Parameters:
- `IMG_WIDTH`, 640: active pixels per line; sets line-buffer depth.
- `KSIZE`, 3: kernel size, 3 or 5 only; any other value is an elaboration error.

Ports:
- `sys_clk`  in  1  pixel clock; all logic on rising edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `cfg_mode`  in  2  0 = bypass, 1 = erode (AND, shrinks white), 2 = dilate (OR, grows white), 3 = bypass.
- `wr_en`  in  1  input pixel valid.
- `img_1bit_in`  in  1  input pixel; 1 = white, 0 = black.
- `pre_href`  in  1  input line-active framing.
- `pre_vsync`  in  1  input frame framing; rising edge = frame start.
- `morph_href`  out  1  `pre_href` delayed 2 clk.
- `morph_vsync`  out  1  `pre_vsync` delayed 2 clk.
- `morph_wr_en`  out  1  `wr_en` delayed 2 clk.
- `img_1bit_out`  out  1  result pixel; forced 0 when `morph_wr_en` = 0.
- `morph_rgb565`  out  16  16'hFFFF if `img_1bit_out` else 16'h0000.
- `line_ovf`  out  1  sticky: some line this frame had more than `IMG_WIDTH` valid pixels.

## Operation
- **Mode latch.** `cfg_mode` is sampled into `mode_q` on each `pre_vsync` rising edge. A change mid-frame has no effect until the next frame. The reset value of `mode_q` is bypass.
- **Counters.**
  - `col_cnt` increments on each `wr_en` and clears on the `pre_href` falling edge. It saturates at `IMG_WIDTH`.
  - `row_cnt` increments on the `pre_href` falling edge and clears on the `pre_vsync` rising edge. It saturates at KSIZE-1; it only gates the upper-row taps.
- **Line buffers.** KSIZE-1 chained delay lines, each `IMG_WIDTH` deep, addressed by `col_cnt`. They are written only on `wr_en` while `col_cnt` < `IMG_WIDTH`.
- **Window.** The window is KSIZE rows × KSIZE columns, anchored with its bottom-right tap on the current input pixel. The output image is therefore shifted by (KSIZE-1)/2 rows and columns relative to the input. Column taps are shift registers advanced on `wr_en`.
- **Out-of-frame taps** are replaced by the neutral value: 1 for erode, 0 for dilate. A tap is out of frame when:
  - it is a row above row 0 (tap row index > `row_cnt`), or
  - it is a column left of column 0 (tap column index > `col_cnt`).
- **Overflow.** A `wr_en` with `col_cnt` = `IMG_WIDTH` sets `line_ovf`. The pixel is still output, using its current window taps, but it is not written to the line buffers. `line_ovf` clears on the `pre_vsync` rising edge.
- **Bypass.** Output is `img_1bit_in` delayed 2 clk.
- **Reset.** All outputs, counters, tap registers and `line_ovf` go to 0 and `mode_q` to bypass. Line-buffer RAM contents are not reset; the neutral-tap masking after the frame start makes this invisible. A reset mid-frame discards the frame; output is valid from the next `pre_vsync` rising edge.

## Timing
- Fixed latency is 2 clk from `wr_en`/`img_1bit_in` to `morph_wr_en`/`img_1bit_out`, for all modes and both KSIZE values.
  - Stage 1 registers the per-row reductions (KSIZE taps → 1 each).
  - Stage 2 registers the column reduction.
- `href`/`vsync`/`wr_en` use matching 2-deep shift registers, so framing stays aligned with data.
- Line-buffer reads are combinational or same-cycle registered. The implementation keeps total latency at exactly 2; if RAM read latency forces a change, the framing delays change with it and the spec is updated.
- Back-to-back `wr_en` every clk is supported. Gaps in `wr_en` within a line stall the window and the counters.

## Structure
- Shared package `isp_morph_pkg` holds:
  - mode constants `MODE_BYPASS`, `MODE_ERODE`, `MODE_DILATE`;
  - the `LAT` = 2 constant;
  - a function returning the neutral value for a mode.
- One sub-module, `isp_1bit_line_buf`: a single `IMG_WIDTH`-deep 1-bit delay line with write enable. It is instantiated KSIZE-1 times in a generate loop.

## Test plan
- **Bypass.** `IMG_WIDTH`=8, KSIZE=3, mode 0, random 8×4 frame → output equals input delayed 2 clk; `morph_rgb565` is FFFF/0000 accordingly.
- **Erode, single black pixel.** KSIZE=3, all-white frame with one black pixel at (row 2, col 3) → a 3×3 black block with bottom-right at (row 4, col 5) in output coordinates, i.e. input rows 2–4 and cols 3–5 window positions. Frame edges stay white (neutral 1).
- **Dilate, single white pixel.** KSIZE=5, all-black frame with one white pixel at (1,1) → white over output rows 1–5 and cols 1–5 (clipped to the frame). No white appears from stale RAM data.
- **Mode change mid-frame.** Switch erode→dilate at row 2 → the frame stays erode; the next frame is dilate.
- **Overflow.** A line with 10 `wr_en` at `IMG_WIDTH`=8 → `line_ovf` = 1 until the next vsync rising edge, then 0. The following line is processed correctly.
- **Reset mid-frame.** Assert `sys_rst` at row 2 → all outputs 0 immediately. After release, the next frame matches the reference model bit-exactly.

Source files
------------

// File: rtl/isp_morph_pkg.sv
// isp_morph_pkg: mode encoding, pipeline latency and neutral-tap helper shared by the morphology stage
package isp_morph_pkg;
  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_ERODE  = 2'd1;
  localparam logic [1:0] MODE_DILATE = 2'd2;
  localparam int LAT = 2;
  function automatic logic neutral(input logic [1:0] mode);
    return mode == MODE_ERODE;
  endfunction
endpackage

// File: rtl/isp_1bit_line_buf.sv
// isp_1bit_line_buf: one image line of 1-bit pixels, combinational read and write at the same address
module isp_1bit_line_buf #(
  parameter int IMG_WIDTH = 640,
  localparam int AW = $clog2(IMG_WIDTH + 1)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          din,
  output logic          dout
);
  logic mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[addr] <= din;
  assign dout = mem[addr];
endmodule

// File: rtl/isp_1bit_morph.sv
// isp_1bit_morph: KSIZE x KSIZE binary erode/dilate/bypass on a framed 1-bit stream, fixed 2-clk latency
module isp_1bit_morph
  import isp_morph_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int KSIZE = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [1:0]  cfg_mode,
  input  logic        wr_en,
  input  logic        img_1bit_in,
  input  logic        pre_href,
  input  logic        pre_vsync,
  output logic        morph_href,
  output logic        morph_vsync,
  output logic        morph_wr_en,
  output logic        img_1bit_out,
  output logic [15:0] morph_rgb565,
  output logic        line_ovf
);
  localparam int AW = $clog2(IMG_WIDTH + 1);
  localparam int RW = $clog2(KSIZE);
  localparam logic [AW-1:0] W_MAX = AW'(IMG_WIDTH);
  localparam logic [RW-1:0] R_MAX = RW'(KSIZE - 1);
  if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
    $error("isp_1bit_morph: KSIZE must be 3 or 5");
  end
  logic [LAT-1:0] href_sr, vsync_sr, wr_sr;
  logic [1:0] mode_q;
  logic [AW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [KSIZE-2:0] sr [KSIZE];
  logic [KSIZE-1:0] row_px, cur, win, red_c, red;
  logic href_fall, vsync_rise, at_max, wr_ok, neu, byp;
  assign href_fall = href_sr[0] & ~pre_href;
  assign vsync_rise = pre_vsync & ~vsync_sr[0];
  assign at_max = col_cnt == W_MAX;
  assign wr_ok = wr_en & ~at_max;
  assign row_px[0] = img_1bit_in;
  // each buffer feeds the next, so buffer i holds the line i+1 rows above
  for (genvar i = 0; i < KSIZE - 1; i++) begin : g_lb
    isp_1bit_line_buf #(.IMG_WIDTH(IMG_WIDTH)) u_lb (
      .clk (sys_clk),
      .we  (wr_ok),
      .addr(col_cnt),
      .din (row_px[i]),
      .dout(row_px[i+1])
    );
  end
  // overflow pixels have no stored column above them, so upper rows see the neutral value
  always_comb begin
    neu = neutral(mode_q);
    cur = '0;
    win = '0;
    red_c = '0;
    for (int k = 0; k < KSIZE; k++) begin
      cur[k] = (k > 0 && at_max) ? neu : row_px[k];
      win = {sr[k], cur[k]};
      for (int j = 0; j < KSIZE; j++)
        win[j] = (j > int'(col_cnt) || k > int'(row_cnt)) ? neu : win[j];
      red_c[k] = (mode_q == MODE_ERODE) ? &win : |win;
    end
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      href_sr <= '0;
      vsync_sr <= '0;
      wr_sr <= '0;
      mode_q <= MODE_BYPASS;
      col_cnt <= '0;
      row_cnt <= '0;
      line_ovf <= 1'b0;
      for (int k = 0; k < KSIZE; k++) sr[k] <= '0;
      red <= '0;
      byp <= 1'b0;
      img_1bit_out <= 1'b0;
    end else begin
      href_sr <= {href_sr[LAT-2:0], pre_href};
      vsync_sr <= {vsync_sr[LAT-2:0], pre_vsync};
      wr_sr <= {wr_sr[LAT-2:0], wr_en};
      if (vsync_rise) mode_q <= cfg_mode;
      col_cnt <= href_fall ? '0 : col_cnt + AW'(wr_ok);
      row_cnt <= vsync_rise ? '0 : row_cnt + RW'(href_fall && row_cnt != R_MAX);
      line_ovf <= !vsync_rise && (line_ovf || (wr_en && at_max));
      if (wr_en)
        for (int k = 0; k < KSIZE; k++) sr[k] <= {sr[k][KSIZE-3:0], cur[k]};
      red <= red_c;
      byp <= img_1bit_in;
      img_1bit_out <= wr_sr[0] && (mode_q == MODE_ERODE ? &red : mode_q == MODE_DILATE ? |red : byp);
    end
  assign morph_href = href_sr[LAT-1];
  assign morph_vsync = vsync_sr[LAT-1];
  assign morph_wr_en = wr_sr[LAT-1];
  assign morph_rgb565 = {16{img_1bit_out}};
endmodule
